// File: rtl/conva1_ofm_writer_if.sv
// Stream-in / bank-write-out bundle of the conv OFM writer.
// slave is the writer's view; master is the datapath/memory side that drives the stream.
interface conva1_ofm_writer_if #(
    parameter int DATA_WIDTH            = 32,
    parameter int ADDRESS_SIZE_NEXT_IFM = 10,
    parameter int NUMBER_OF_IFM_NEXT    = 3
);
    logic [DATA_WIDTH-1:0]            data_in;
    logic                             data_in_valid;
    logic [DATA_WIDTH-1:0]            data_out_next;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] address_next;
    logic [NUMBER_OF_IFM_NEXT-1:0]    ifm_enable_write_next;

    modport master (
        output data_in, data_in_valid,
        input  data_out_next, address_next, ifm_enable_write_next
    );

    modport slave (
        input  data_in, data_in_valid,
        output data_out_next, address_next, ifm_enable_write_next
    );
endinterface

// File: rtl/conva1_ofm_writer.sv
// Writes the serial filter-major OFM stream into the next layer's IFM banks,
// generating pixel address and one-hot bank enable; reports done and protocol errors.
module conva1_ofm_writer #(
    parameter int DATA_WIDTH                  = 32,
    parameter int IFM_SIZE_NEXT               = 28,
    parameter int NUMBER_OF_IFM_NEXT          = 3,
    parameter int ADDRESS_SIZE_NEXT_IFM       = $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT),
    parameter int NUMBER_OF_BITS_SEL_IFM_NEXT = (NUMBER_OF_IFM_NEXT > 1) ? $clog2(NUMBER_OF_IFM_NEXT) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    conva1_ofm_writer_if.slave        wr,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] PIX_LAST =
        ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT*IFM_SIZE_NEXT - 1);
    localparam logic [NUMBER_OF_BITS_SEL_IFM_NEXT-1:0] FILT_LAST =
        NUMBER_OF_BITS_SEL_IFM_NEXT'(NUMBER_OF_IFM_NEXT - 1);

    logic [1:0]                             state_reg, state_next;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0]       pix_reg, pix_next;
    logic [NUMBER_OF_BITS_SEL_IFM_NEXT-1:0] filt_reg, filt_next;
    logic                                   error_reg, error_next;
    logic [DATA_WIDTH-1:0]                  data_out_reg;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0]       address_reg;
    logic [NUMBER_OF_IFM_NEXT-1:0]          we_reg, we_next;
    logic [NUMBER_OF_IFM_NEXT-1:0]          bank_onehot;
    logic                                   accept;
    logic                                   pix_wrap;
    logic                                   last_sample;

    genvar gi;
    generate
        for (gi = 0; gi < NUMBER_OF_IFM_NEXT; gi++) begin : g_bank_sel
            assign bank_onehot[gi] = (filt_reg == NUMBER_OF_BITS_SEL_IFM_NEXT'(gi));
        end
    endgenerate

    assign accept      = wr.data_in_valid && (state_reg == ST_RUN);
    assign pix_wrap    = (pix_reg == PIX_LAST);
    assign last_sample = accept && pix_wrap && (filt_reg == FILT_LAST);
    assign we_next     = accept ? bank_onehot : '0;

    always_comb begin
        state_next = state_reg;
        pix_next   = pix_reg;
        filt_next  = filt_reg;
        error_next = error_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    pix_next   = '0;
                    filt_next  = '0;
                    error_next = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (pix_wrap) begin
                        pix_next  = '0;
                        filt_next = filt_reg + 1'b1;
                    end else begin
                        pix_next = pix_reg + 1'b1;
                    end
                end
                if (last_sample) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        // Evaluated after the start-clear so a same-cycle protocol error wins.
        if ((wr.data_in_valid && (state_reg != ST_RUN)) ||
            (start && (state_reg != ST_IDLE))) begin
            error_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            pix_reg      <= '0;
            filt_reg     <= '0;
            error_reg    <= 1'b0;
            data_out_reg <= '0;
            address_reg  <= '0;
            we_reg       <= '0;
        end else begin
            state_reg <= state_next;
            pix_reg   <= pix_next;
            filt_reg  <= filt_next;
            error_reg <= error_next;
            we_reg    <= we_next;
            if (accept) begin
                data_out_reg <= wr.data_in;
                address_reg  <= pix_reg;
            end
        end
    end

    assign wr.data_out_next         = data_out_reg;
    assign wr.address_next          = address_reg;
    assign wr.ifm_enable_write_next = we_reg;
    assign busy  = (state_reg == ST_RUN);
    assign done  = (state_reg == ST_DONE);
    assign error = error_reg;
endmodule
